// File: rtl/pc_seq_unit.sv
// pc_seq_unit
// Program-counter sequencer for the WISC-15 fetch stage. Holds the PC,
// resolves conditional branches against the Z/V/N flags, keeps a hardware
// return-address stack (RAS) for call/ret, and provides stall and sticky
// halt control. The registered PC drives the instruction memory address.
//
// Ports:
//   clk, rst_n            rising-edge clock, asynchronous active-low reset
//   stall                 hold PC, RAS and halt state this cycle
//   branch/call/ret/halt  decoded control of the instruction at pc
//   cond, z, v, n         branch condition code and ALU flags
//   b_imm, c_imm          signed branch / call offsets
//   ret_reg               return address used when the RAS is empty
//   pc                    registered current PC
//   next_pc               value pc takes at the next rising edge
//   halted                sticky halt indicator
//   ras_count             number of valid RAS entries
//   ras_overflow          one-cycle pulse: a push evicted the oldest entry
//   ras_underflow         one-cycle pulse: ret with an empty RAS
module pc_seq_unit #(
    parameter int               WIDTH     = 16,
    parameter int               RAS_DEPTH = 8,
    parameter logic [WIDTH-1:0] RESET_PC  = '0
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         stall,
    input  logic                         branch,
    input  logic                         call,
    input  logic                         ret,
    input  logic                         halt,
    input  logic [2:0]                   cond,
    input  logic                         z,
    input  logic                         v,
    input  logic                         n,
    input  logic [WIDTH-1:0]             b_imm,
    input  logic [WIDTH-1:0]             c_imm,
    input  logic [WIDTH-1:0]             ret_reg,
    output logic [WIDTH-1:0]             pc,
    output logic [WIDTH-1:0]             next_pc,
    output logic                         halted,
    output logic [$clog2(RAS_DEPTH):0]   ras_count,
    output logic                         ras_overflow,
    output logic                         ras_underflow
);

    localparam int              PW   = $clog2(RAS_DEPTH);
    localparam int              CW   = PW + 1;
    localparam logic [CW-1:0]   FULL = CW'(RAS_DEPTH);

    logic [WIDTH-1:0] ras_mem [RAS_DEPTH];
    // ras_ptr is the next free slot; the top of stack sits just below it.
    // Because RAS_DEPTH is a power of two the pointer wraps naturally, so a
    // push into a full stack overwrites the oldest entry.
    logic [PW-1:0]    ras_ptr;
    logic [PW-1:0]    ras_top;
    logic             ras_empty;
    logic             ras_full;

    logic             active;
    logic             cond_true;
    logic             push;
    logic             pop;
    logic             set_halt;
    logic [WIDTH-1:0] pc_inc;

    assign ras_top   = ras_ptr - PW'(1);
    assign ras_empty = (ras_count == '0);
    assign ras_full  = (ras_count == FULL);
    assign active    = !halted && !stall;
    assign pc_inc    = pc + WIDTH'(1);

    always_comb begin
        cond_true = 1'b0;
        case (cond)
            3'b000:  cond_true = !z;
            3'b001:  cond_true = z;
            3'b010:  cond_true = !z && !n;
            3'b011:  cond_true = n;
            3'b100:  cond_true = z || !n;
            3'b101:  cond_true = n || z;
            3'b110:  cond_true = v;
            default: cond_true = 1'b1;
        endcase
    end

    // Next-PC selection; the if/else chain encodes strobe priority so a
    // lower-priority strobe never has a side effect when a higher one is set.
    always_comb begin
        next_pc  = pc;
        push     = 1'b0;
        pop      = 1'b0;
        set_halt = 1'b0;
        if (active) begin
            if (branch) begin
                next_pc = cond_true ? (pc_inc + b_imm) : pc_inc;
            end else if (call) begin
                next_pc = pc_inc + c_imm;
                push    = 1'b1;
            end else if (ret) begin
                pop     = 1'b1;
                next_pc = ras_empty ? ret_reg : ras_mem[ras_top];
            end else if (halt) begin
                set_halt = 1'b1;
            end else begin
                next_pc = pc_inc;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc            <= RESET_PC;
            halted        <= 1'b0;
            ras_ptr       <= '0;
            ras_count     <= '0;
            ras_overflow  <= 1'b0;
            ras_underflow <= 1'b0;
        end else begin
            pc            <= next_pc;
            halted        <= halted || set_halt;
            ras_overflow  <= push && ras_full;
            ras_underflow <= pop && ras_empty;
            if (push) begin
                ras_ptr <= ras_ptr + PW'(1);
                if (!ras_full) begin
                    ras_count <= ras_count + CW'(1);
                end
            end else if (pop && !ras_empty) begin
                ras_ptr   <= ras_ptr - PW'(1);
                ras_count <= ras_count - CW'(1);
            end
        end
    end

    // Stack contents need no reset; validity is tracked by ras_count.
    always_ff @(posedge clk) begin
        if (push) begin
            ras_mem[ras_ptr] <= pc_inc;
        end
    end

endmodule

// File: doc/pc_seq_unit.md
# pc_seq_unit

Parametrised program-counter sequencer for the WISC-15 fetch stage. It holds the PC register and evaluates conditional branches against the Z/V/N flags. It adds a hardware return-address stack (RAS) so `ret` needs no register-file read, plus stall and sticky-halt control. It feeds the instruction memory address each cycle.

## Interface
- `WIDTH`, 16, PC and immediate width
- `RAS_DEPTH`, 8, return-address stack entries (power of two, >=2)
- `RESET_PC`, 0, PC value after reset
- `clk` in 1: rising-edge clock
- `rst_n` in 1: reset, asynchronous, active-low
- `stall` in 1: hold PC and RAS this cycle
- `branch`, `call`, `ret`, `halt` in 1 each: decoded control of the instruction at `pc`
- `cond` in 3: branch condition code
- `z`, `v`, `n` in 1 each: ALU flags
- `b_imm`, `c_imm` in WIDTH: signed branch/call offsets (two's complement)
- `ret_reg` in WIDTH: fallback return address used when RAS is empty
- `pc` out WIDTH: registered current PC
- `next_pc` out WIDTH: combinational value `pc` takes at the next edge
- `halted` out 1: sticky halt indicator
- `ras_count` out $clog2(RAS_DEPTH)+1: valid RAS entries
- `ras_overflow` out 1: one-cycle pulse, a push evicted the oldest entry
- `ras_underflow` out 1: one-cycle pulse, `ret` with empty RAS

## Operation
- Sequential `pc+1` = `pc + 1`. All arithmetic is modulo 2^WIDTH; wrap from all-ones to 0 is legal.
- Next-PC source, priority highest first:
  - `halted`=1 or `stall`=1: `pc`.
  - `branch`: `pc+1+b_imm` if the condition holds, else `pc+1`.
  - `call`: `pc+1+c_imm`; push `pc+1`.
  - `ret`: pop RAS top; if RAS is empty use `ret_reg`.
  - `halt`: `pc`; set `halted`.
  - otherwise: `pc+1`.
- Lower-priority strobes are ignored when a higher one is asserted, e.g. `branch`+`call` pushes nothing.
- Conditions:
  - 000 NE `!z`
  - 001 EQ `z`
  - 010 GT `!z && !n`
  - 011 LT `n`
  - 100 GE `z || !n`
  - 101 LE `n || z`
  - 110 OV `v`
  - 111 always
- RAS is a circular buffer with a top pointer and a saturating count.
  - Push when full: overwrite the oldest entry, count stays `RAS_DEPTH`, pulse `ras_overflow`.
  - Pop when count=0: no pointer change, pulse `ras_underflow`.
- `halted` is sticky until `rst_n` is asserted. While halted, all inputs are ignored and no RAS change occurs.
- `stall` blocks every state change, including setting `halted` and the overflow/underflow pulses.

## Timing
- Reset (async, `rst_n`=0): `pc`=`RESET_PC`, `halted`=0, `ras_count`=0, `ras_overflow`=0, `ras_underflow`=0, RAS pointer=0. RAS contents are don't-care.
  - Reset asserted mid-operation clears all of the above immediately, without waiting for a clock edge.
- `next_pc` is combinational from the current inputs and state. `pc`, RAS, `halted` and the flag pulses update on the rising edge of `clk`.
- Latency: one cycle from control input to `pc`. A pushed address is poppable by a `ret` in the next cycle.
- Pulses `ras_overflow`/`ras_underflow` are registered: high exactly one cycle after the offending edge, then low unless the event repeats.
- First edge after `rst_n` deassertion performs a normal update.

## Test plan
- Reset, then 3 idle cycles, RESET_PC=0 -> `pc` = 0, 1, 2, 3; `halted`=0, `ras_count`=0.
- `pc`=0x0010, `branch`, `cond`=010, z=0, n=0, `b_imm`=0xFFFB (-5) -> `pc`=0x000C. Repeat with n=1 -> `pc`=0x0011. Sweep all 8 conds over all 8 z/v/n combinations against the table.
- Call/return: `pc`=0x0020, `call`, `c_imm`=0x0100 -> `pc`=0x0121, `ras_count`=1. Next `ret` with `ret_reg`=0xBEEF -> `pc`=0x0021, `ras_count`=0.
- RAS boundaries, RAS_DEPTH=8:
  - 9 nested calls -> `ras_overflow` pulses once on the 9th, `ras_count`=8.
  - 8 rets return the latest 8 addresses in LIFO order.
  - A 9th `ret` with `ret_reg`=0x1234 -> `pc`=0x1234, `ras_underflow` pulses.
- Stall and halt:
  - `stall` held with `call` for 2 cycles -> `pc` and `ras_count` unchanged.
  - `halt` at `pc`=0x0040 -> `halted`=1, `pc` stays 0x0040 through a later `branch` with cond=111.
  - `rst_n` pulse low mid-cycle -> `pc`=0, `halted`=0 before the next edge.
- Wrap: `pc`=0xFFFF idle -> `pc`=0x0000. Branch from 0x0000 with `b_imm`=0xFFFE -> `pc`=0xFFFF.
